// File: rtl/id_scoreboard_pkg.sv
// Shared types for the decode-stage long-op hazard scoreboard: register
// address bus, FSM encoding and the per-register hit test.
package id_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    SB_RUN   = 2'd0,
    SB_DRAIN = 2'd1,
    SB_DONE  = 2'd2
  } sb_state_e;

  // A pending register is not a hazard in the cycle its result is written,
  // because the register file forwards the write port to the read ports.
  function automatic logic reg_hit(input logic [NUM_REGS-1:0] busy,
                                   input reg_addr_t r,
                                   input logic wb_valid,
                                   input reg_addr_t wb_rd);
    return busy[r] && (r != '0) && !(wb_valid && (wb_rd == r));
  endfunction

endpackage

// File: rtl/id_scoreboard_if.sv
// Decode/writeback/drain signals between id, ctrl, ex and the scoreboard.
// The master drives instruction, writeback and drain-request signals; the
// scoreboard (slave) answers with stall, pending bitmap and drain status.
interface id_scoreboard_if #(
  parameter int CNT_W = 2
);
  import id_scoreboard_pkg::*;

  logic               id_valid_i;
  reg_addr_t          id_rs1_i;
  reg_addr_t          id_rs2_i;
  reg_addr_t          id_rd_i;
  logic               id_rd_we_i;
  logic               id_long_i;
  logic               flush_i;
  logic               wb_valid_i;
  reg_addr_t          wb_rd_i;
  logic               drain_req_i;

  logic               id_stall_o;
  logic               drain_ack_o;
  logic [NUM_REGS-1:0] busy_o;
  logic [CNT_W-1:0]   outstanding_o;
  logic               err_o;
  sb_state_e          sb_state_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_rd_we_i, id_long_i,
    output flush_i, wb_valid_i, wb_rd_i, drain_req_i,
    input  id_stall_o, drain_ack_o, busy_o, outstanding_o, err_o, sb_state_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_rd_we_i, id_long_i,
    input  flush_i, wb_valid_i, wb_rd_i, drain_req_i,
    output id_stall_o, drain_ack_o, busy_o, outstanding_o, err_o, sb_state_o
  );

endinterface

// File: rtl/id_scoreboard.sv
// Tracks destination registers of in-flight long ops (DIV family), stalls
// decode on RAW/WAW hazards or when too many are outstanding, and drains.
module id_scoreboard
  import id_scoreboard_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic            clk,
  input  logic            rst,
  id_scoreboard_if.slave  sb
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [NUM_REGS-1:0] busy_q;
  logic [CNT_W-1:0]    cnt_q;
  sb_state_e           state_q;
  logic                ack_q;
  logic                err_q;

  logic                hazard;
  logic                long_block;
  logic                stall;
  logic                issue;
  logic                retire;
  logic                spurious;
  logic [NUM_REGS-1:0] busy_next;
  logic [CNT_W-1:0]    cnt_next;
  sb_state_e           state_next;

  always_comb begin
    hazard = reg_hit(busy_q, sb.id_rs1_i, sb.wb_valid_i, sb.wb_rd_i)
           | reg_hit(busy_q, sb.id_rs2_i, sb.wb_valid_i, sb.wb_rd_i)
           | (sb.id_rd_we_i & reg_hit(busy_q, sb.id_rd_i, sb.wb_valid_i, sb.wb_rd_i));
    // A completion this cycle frees a slot, so a full counter does not block.
    long_block = sb.id_long_i
               & (((cnt_q == CNT_MAX) & ~sb.wb_valid_i) | (state_q != SB_RUN));
    stall    = sb.id_valid_i & (hazard | long_block);
    issue    = sb.id_valid_i & sb.id_long_i & ~stall & ~sb.flush_i;
    retire   = sb.wb_valid_i & (cnt_q != '0);
    spurious = sb.wb_valid_i & (cnt_q == '0);
  end

  always_comb begin
    busy_next = busy_q;
    if (retire) begin
      busy_next[sb.wb_rd_i] = 1'b0;
    end
    // Set after clear: an issue to the register that is retiring keeps it busy.
    if (issue && sb.id_rd_we_i && (sb.id_rd_i != '0)) begin
      busy_next[sb.id_rd_i] = 1'b1;
    end
    busy_next[0] = 1'b0;
    cnt_next = cnt_q + CNT_W'(issue) - CNT_W'(retire);
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      SB_RUN:   if (sb.drain_req_i) state_next = SB_DRAIN;
      SB_DRAIN: begin
        if (!sb.drain_req_i)       state_next = SB_RUN;
        else if (cnt_next == '0)   state_next = SB_DONE;
      end
      SB_DONE:  if (!sb.drain_req_i) state_next = SB_RUN;
      default:  state_next = SB_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q  <= '0;
      cnt_q   <= '0;
      state_q <= SB_RUN;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_next;
      cnt_q   <= cnt_next;
      state_q <= state_next;
      ack_q   <= (state_next == SB_DONE);
      err_q   <= spurious;
    end
  end

  assign sb.id_stall_o    = stall;
  assign sb.busy_o        = busy_q;
  assign sb.outstanding_o = cnt_q;
  assign sb.drain_ack_o   = ack_q;
  assign sb.err_o         = err_q;
  assign sb.sb_state_o    = state_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard: each cycle's stimulus pushes the
// hand-computed outputs for that cycle; a monitor pops and compares them.
module tb_id_scoreboard;
  import id_scoreboard_pkg::*;

  localparam int CNT_W = 2;
  localparam int W     = 1 + 32 + CNT_W + 1 + 1;
  localparam logic [2:0] NOP = 3'b000;  // {valid, long, rd_we}
  localparam logic [2:0] ADD = 3'b101;
  localparam logic [2:0] DIV = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic chk_valid = 1'b0;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_vec = 0;
  int           n_err = 0;

  id_scoreboard_if #(.CNT_W(CNT_W)) sbif ();

  id_scoreboard #(.MAX_OUTSTANDING(2)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sbif)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  // Driver: apply one cycle of stimulus and queue that cycle's expected outputs.
  task automatic cyc(input string nm, input logic r, input logic [2:0] kind,
                     input reg_addr_t rs1, input reg_addr_t rs2, input reg_addr_t rd,
                     input logic fl, input logic wv, input reg_addr_t wrd, input logic dr,
                     input logic e_stall, input logic [31:0] e_busy,
                     input logic [CNT_W-1:0] e_out, input logic e_ack, input logic e_err);
    @(negedge clk);
    #1;
    rst                  = r;
    sbif.id_valid_i      = kind[2];
    sbif.id_long_i       = kind[1];
    sbif.id_rd_we_i      = kind[0];
    sbif.id_rs1_i        = rs1;
    sbif.id_rs2_i        = rs2;
    sbif.id_rd_i         = rd;
    sbif.flush_i         = fl;
    sbif.wb_valid_i      = wv;
    sbif.wb_rd_i         = wrd;
    sbif.drain_req_i     = dr;
    exp_q.push_back({e_stall, e_busy, e_out, e_ack, e_err});
    name_q.push_back(nm);
    chk_valid = 1'b1;
  endtask

  // Monitor / scoreboard: sample mid-low-phase, well away from the rising edge.
  initial begin
    logic [W-1:0] act;
    logic [W-1:0] exp;
    string        nm;
    forever begin
      @(negedge clk);
      #3;
      if (chk_valid) begin
        act = {sbif.id_stall_o, sbif.busy_o, sbif.outstanding_o,
               sbif.drain_ack_o, sbif.err_o};
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL queue_underrun: got outputs %h, expected a queued vector", act);
        end else begin
          exp = exp_q.pop_front();
          nm  = name_q.pop_front();
          if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got stall=%0b busy=%h out=%0d ack=%0b err=%0b, expected stall=%0b busy=%h out=%0d ack=%0b err=%0b",
                     nm, act[W-1], act[W-2 -: 32], act[2+CNT_W-1 -: CNT_W], act[1], act[0],
                     exp[W-1], exp[W-2 -: 32], exp[2+CNT_W-1 -: CNT_W], exp[1], exp[0]);
          end
        end
      end
    end
  end

  initial begin
    sbif.id_valid_i = 0; sbif.id_long_i = 0; sbif.id_rd_we_i = 0;
    sbif.id_rs1_i = 0; sbif.id_rs2_i = 0; sbif.id_rd_i = 0;
    sbif.flush_i = 0; sbif.wb_valid_i = 0; sbif.wb_rd_i = 0; sbif.drain_req_i = 0;
    repeat (2) @(posedge clk);

    //   name            rst kind rs1 rs2 rd  fl wv wrd dr | stall busy         out ack err
    cyc("in_reset",      0, NOP, 0,  0,  0,  0, 0, 0,  0,   0, 32'h0,         0, 0, 0);
    cyc("reset_release", 1, NOP, 0,  0,  0,  0, 0, 0,  0,   0, 32'h0,         0, 0, 0);
    // RAW on x5
    cyc("div_x5",        1, DIV, 1,  2,  5,  0, 0, 0,  0,   0, 32'h0,         0, 0, 0);
    cyc("raw_x5_a",      1, ADD, 5,  0,  8,  0, 0, 0,  0,   1, 32'h20,        1, 0, 0);
    cyc("raw_x5_b",      1, ADD, 5,  0,  8,  0, 0, 0,  0,   1, 32'h20,        1, 0, 0);
    cyc("raw_x5_wb",     1, ADD, 5,  0,  8,  0, 1, 5,  0,   0, 32'h20,        1, 0, 0);
    cyc("x5_cleared",    1, NOP, 0,  0,  0,  0, 0, 0,  0,   0, 32'h0,         0, 0, 0);
    // Outstanding cap
    cyc("div_x3",        1, DIV, 1,  2,  3,  0, 0, 0,  0,   0, 32'h0,         0, 0, 0);
    cyc("div_x4",        1, DIV, 1,  2,  4,  0, 0, 0,  0,   0, 32'h8,         1, 0, 0);
    cyc("cap_stall",     1, DIV, 1,  2,  6,  0, 0, 0,  0,   1, 32'h18,        2, 0, 0);
    cyc("cap_wb_release",1, DIV, 1,  2,  6,  0, 1, 3,  0,   0, 32'h18,        2, 0, 0);
    cyc("cap_swap",      1, NOP, 0,  0,  0,  0, 1, 4,  0,   0, 32'h50,        2, 0, 0);
    cyc("wb_x6",         1, NOP, 0,  0,  0,  0, 1, 6,  0,   0, 32'h40,        1, 0, 0);
    // x0 destination
    cyc("div_x0",        1, DIV, 1,  2,  0,  0, 0, 0,  0,   0, 32'h0,         0, 0, 0);
    cyc("add_reads_x0",  1, ADD, 0,  0,  9,  0, 0, 0,  0,   0, 32'h0,         1, 0, 0);
    cyc("wb_x0",         1, NOP, 0,  0,  0,  0, 1, 0,  0,   0, 32'h0,         1, 0, 0);
    // Flushed issue
    cyc("div_x7_flush",  1, DIV, 1,  2,  7,  1, 0, 0,  0,   0, 32'h0,         0, 0, 0);
    cyc("after_flush",   1, NOP, 0,  0,  0,  0, 0, 0,  0,   0, 32'h0,         0, 0, 0);
    // Same-rd issue and completion; WAW
    cyc("div_x10",       1, DIV, 1,  2,  10, 0, 0, 0,  0,   0, 32'h0,         0, 0, 0);
    cyc("div_x10_wb10",  1, DIV, 1,  2,  10, 0, 1, 10, 0,   0, 32'h400,       1, 0, 0);
    cyc("waw_div_x10",   1, DIV, 1,  2,  10, 0, 0, 0,  0,   1, 32'h400,       1, 0, 0);
    cyc("waw_add_x10",   1, ADD, 1,  2,  10, 0, 0, 0,  0,   1, 32'h400,       1, 0, 0);
    // Drain with one op in flight
    cyc("drain_req",     1, NOP, 0,  0,  0,  0, 0, 0,  1,   0, 32'h400,       1, 0, 0);
    cyc("drain_div",     1, DIV, 1,  2,  11, 0, 0, 0,  1,   1, 32'h400,       1, 0, 0);
    cyc("drain_add",     1, ADD, 1,  2,  12, 0, 0, 0,  1,   0, 32'h400,       1, 0, 0);
    cyc("drain_wb",      1, NOP, 0,  0,  0,  0, 1, 10, 1,   0, 32'h400,       1, 0, 0);
    cyc("drain_ack",     1, NOP, 0,  0,  0,  0, 0, 0,  1,   0, 32'h0,         0, 1, 0);
    cyc("drain_drop",    1, NOP, 0,  0,  0,  0, 0, 0,  0,   0, 32'h0,         0, 1, 0);
    cyc("run_again",     1, DIV, 1,  2,  13, 0, 0, 0,  0,   0, 32'h0,         0, 0, 0);
    cyc("wb_x13",        1, NOP, 0,  0,  0,  0, 1, 13, 0,   0, 32'h2000,      1, 0, 0);
    // Drain while idle: ack two edges after the request
    cyc("idle_drain_0",  1, NOP, 0,  0,  0,  0, 0, 0,  1,   0, 32'h0,         0, 0, 0);
    cyc("idle_drain_1",  1, NOP, 0,  0,  0,  0, 0, 0,  1,   0, 32'h0,         0, 0, 0);
    cyc("idle_drain_2",  1, NOP, 0,  0,  0,  0, 0, 0,  1,   0, 32'h0,         0, 1, 0);
    cyc("idle_drop",     1, NOP, 0,  0,  0,  0, 0, 0,  0,   0, 32'h0,         0, 1, 0);
    cyc("idle_run",      1, NOP, 0,  0,  0,  0, 0, 0,  0,   0, 32'h0,         0, 0, 0);
    // Spurious completion
    cyc("spurious_wb",   1, NOP, 0,  0,  0,  0, 1, 3,  0,   0, 32'h0,         0, 0, 0);
    cyc("err_pulse",     1, NOP, 0,  0,  0,  0, 0, 0,  0,   0, 32'h0,         0, 0, 1);
    cyc("err_clear",     1, NOP, 0,  0,  0,  0, 0, 0,  0,   0, 32'h0,         0, 0, 0);
    // Reset mid-flight
    cyc("div_x14",       1, DIV, 1,  2,  14, 0, 0, 0,  0,   0, 32'h0,         0, 0, 0);
    cyc("pre_rst_drain", 1, NOP, 0,  0,  0,  0, 0, 0,  1,   0, 32'h4000,      1, 0, 0);
    cyc("async_rst",     0, ADD, 14, 0,  15, 0, 0, 0,  0,   0, 32'h0,         0, 0, 0);
    cyc("post_rst",      1, NOP, 0,  0,  0,  0, 0, 0,  0,   0, 32'h0,         0, 0, 0);
    cyc("stale_wb",      1, NOP, 0,  0,  0,  0, 1, 14, 0,   0, 32'h0,         0, 0, 0);
    cyc("stale_err",     1, NOP, 0,  0,  0,  0, 0, 0,  0,   0, 32'h0,         0, 0, 1);

    #5;
    chk_valid = 1'b0;
    @(negedge clk);
    #5;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d unchecked vectors, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_scoreboard.md
# id_scoreboard

Register-hazard scoreboard and issue controller for the decode stage. It tracks destination registers of long-latency operations (DIV/DIVU/REM/REMU) that have issued from decode and not yet written back. It stalls decode on RAW or WAW hazards against those registers and caps the number of outstanding long operations. It also provides a drain handshake so interrupt/CSR logic can quiesce the long-op unit. It sits between `id`, `ctrl` and the `ex`/divider writeback path.

## Interface
Parameters:
- MAX_OUTSTANDING, 2: maximum long ops in flight (1..7).
- CNT_W, $clog2(MAX_OUTSTANDING+1): width of the outstanding counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid_i  in  1  decode holds a valid instruction.
- id_rs1_i / id_rs2_i  in  5 each  source register addresses as driven to regs.
- id_rd_i  in  5  destination register.
- id_rd_we_i  in  1  instruction architecturally writes rd (DIV family included).
- id_long_i  in  1  instruction is a long op.
- flush_i  in  1  jump/flush from ex; blocks issue this cycle.
- wb_valid_i  in  1  long-op result written to regs this cycle.
- wb_rd_i  in  5  register written by the completing long op.
- drain_req_i  in  1  level request to stop issuing long ops.
- id_stall_o  out  1  hold decode (combinational).
- drain_ack_o  out  1  drained: no long op in flight (registered).
- busy_o  out  32  per-register pending bitmap; bit 0 is constant 0.
- outstanding_o  out  CNT_W  long ops in flight.
- err_o  out  1  one-cycle pulse on a spurious completion.

## Operation
- hit(r) = busy[r] & (r != 0) & ~(wb_valid_i & wb_rd_i == r). Same-cycle completion is masked because regs forwards its write port to the read ports.
- A hazard exists when hit(rs1), hit(rs2), or (id_rd_we_i & hit(rd)) [WAW].
- A long block exists when id_long_i and either outstanding == MAX_OUTSTANDING (with no wb_valid_i this cycle) or state != RUN.
- id_stall_o = id_valid_i & (hazard | long block).
- A long op issues when id_valid_i & id_long_i & ~id_stall_o & ~flush_i.
  - On issue, set busy[rd] if id_rd_we_i and rd != 0. Increment the counter whenever the op issues, including rd = x0.
- On completion (wb_valid_i):
  - If outstanding == 0, the completion is spurious: pulse err_o, leave the counter unchanged and leave busy unchanged.
  - Otherwise clear busy[wb_rd_i] and decrement the counter.
- Issue and completion in the same cycle: the counter is unchanged. If issue rd == completion rd, busy[rd] ends set (the set wins).
- flush_i does not clear busy or the counter; in-flight long ops always complete.
- FSM, state encoded in 2 bits:
  - RUN: go to DRAIN when drain_req_i.
  - DRAIN: go to DONE when the next outstanding value is 0; go to RUN if drain_req_i drops.
  - DONE: drain_ack_o = 1; go to RUN when drain_req_i drops.
- Non-long instructions are never stalled by the long block, only by hazards.

## Timing
- Reset values: busy 0, counter 0, state RUN, drain_ack_o 0, err_o 0. id_stall_o is combinational, so it is 0 while id_valid_i = 0.
- id_stall_o is combinational from inputs and current state, with zero-cycle latency.
- busy, the counter and outstanding_o update at the issue/completion edge and are visible the next cycle.
- drain_ack_o rises 1 cycle after the edge at which the last completion retires. If drain_req_i arrives with the unit idle, drain_ack_o rises 2 edges later (RUN→DRAIN→DONE).
- err_o is registered and is high for exactly the cycle after a spurious completion.
- Reset asserted mid-operation clears all state immediately. Completions arriving after reset release are treated as spurious.

## Structure
- Add the scoreboard state encodings (SB_RUN=2'd0, SB_DRAIN=2'd1, SB_DONE=2'd2) to defines.v alongside the existing instruction constants. Reuse `RegAddrBus` for the register address ports.
- Sub-module: none required. The busy bitmap, counter and FSM fit in one module of about 200 lines.

## Test plan
- Issue DIV x5, then next cycle an ADD reading x5 → stall held until the wb_valid_i/wb_rd_i=5 cycle, released in that same cycle; busy_o[5] goes 1 then 0.
- With MAX_OUTSTANDING=2, issue DIV x3 and DIV x4, then a third DIV x6 → stalled with outstanding_o=2. A completion of x3 in the same cycle releases it and outstanding_o stays 2.
- DIV x0 → busy_o stays 0 and outstanding_o=1. A following ADD reading x0 is not stalled.
- Issue DIV x7 with flush_i=1 → no busy bit set, counter 0. The flushed-out cycle's state is unchanged.
- Raise drain_req_i with 1 op outstanding → the next DIV stalls and an ADD does not. After the completion, drain_ack_o=1 one cycle later; dropping the request returns the FSM to RUN.
- wb_valid_i with outstanding 0 → err_o pulses for 1 cycle and the counter stays 0. Assert rst mid-flight → all outputs return to their reset values asynchronously.
